// File: rtl/key_pkg.sv
// Shared types and helpers for the debounced key event controller.
// Vectors are passed zero-extended to MAX_KEYS bits so one helper serves every width.
package key_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DEBOUNCE,
      HELD,
      RELEASE,
      ERROR
   } state_t;

   localparam int KEY_ENTER  = 0;
   localparam int KEY_NUMBER = 1;
   localparam int KEY_TOTAL  = 2;
   localparam int KEY_CLEAR  = 3;

   localparam int MAX_KEYS = 32;
   localparam int IDX_W    = $clog2(MAX_KEYS);

   function automatic logic is_onehot(input logic [MAX_KEYS-1:0] vec);
      logic seen;
      logic extra;
      seen  = 1'b0;
      extra = 1'b0;
      for (int i = 0; i < MAX_KEYS; i++) begin
         if (vec[i]) begin
            if (seen) extra = 1'b1;
            seen = 1'b1;
         end
      end
      return seen && !extra;
   endfunction

   // OR of the indices of set bits; exact whenever the input is one-hot.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_KEYS-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_KEYS; i++) begin
         if (vec[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/key_sync.sv
// Per-bit two-flop synchroniser for the raw asynchronous key lines.
module key_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic meta_reg;
         logic stable_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               meta_reg   <= 1'b0;
               stable_reg <= 1'b0;
            end else begin
               meta_reg   <= d[gi];
               stable_reg <= meta_reg;
            end
         end

         assign q[gi] = stable_reg;
      end
   endgenerate

endmodule

// File: rtl/key_event_controller.sv
// Synchronises and debounces N key lines, emitting one event per clean single-key press
// and locking out on multi-key presses until every key has been released and stable.
module key_event_controller
   import key_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CODE_W          = $clog2(N_KEYS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic              key_valid,
   output logic [CODE_W-1:0] key_code,
   output logic [N_KEYS-1:0] key_onehot,
   output logic              err,
   output logic              busy
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

   logic [N_KEYS-1:0] sync;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
   logic [N_KEYS-1:0] cand_reg, cand_next;
   logic              key_valid_reg, key_valid_next;
   logic [CODE_W-1:0] key_code_reg, key_code_next;
   logic [N_KEYS-1:0] key_onehot_reg, key_onehot_next;
   logic              err_reg, busy_reg;

   logic is_zero, is_one, is_multi, same_key, accept;

   key_sync #(
      .WIDTH(N_KEYS)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (key_in),
      .q  (sync)
   );

   assign is_zero  = (sync == '0);
   assign is_one   = is_onehot(MAX_KEYS'(sync));
   assign is_multi = !is_zero && !is_one;
   assign same_key = (sync == cand_reg);
   assign cnt_inc  = cnt_reg + CNT_ONE;

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      cand_next       = cand_reg;
      key_valid_next  = 1'b0;
      key_code_next   = key_code_reg;
      key_onehot_next = key_onehot_reg;
      accept          = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (is_multi) begin
               state_next = ERROR;
               cnt_next   = '0;
            end else if (is_one) begin
               cand_next = sync;
               cnt_next  = CNT_ONE;
               if (CNT_ONE == CNT_DONE) accept = 1'b1;
               else                     state_next = DEBOUNCE;
            end
         end

         DEBOUNCE: begin
            if (is_multi) begin
               state_next = ERROR;
               cnt_next   = '0;
            end else if (is_zero) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (same_key) begin
               cnt_next = cnt_inc;
               if (cnt_inc == CNT_DONE) accept = 1'b1;
            end else begin
               // A different single key restarts the debounce window from scratch.
               cand_next = sync;
               cnt_next  = CNT_ONE;
               if (CNT_ONE == CNT_DONE) accept = 1'b1;
            end
         end

         HELD: begin
            if (is_zero) begin
               cnt_next   = CNT_ONE;
               state_next = (CNT_ONE == CNT_DONE) ? IDLE : RELEASE;
            end else if (!same_key) begin
               state_next = ERROR;
               cnt_next   = '0;
            end
         end

         RELEASE: begin
            if (is_zero) begin
               cnt_next = cnt_inc;
               if (cnt_inc == CNT_DONE) state_next = IDLE;
            end else if (same_key) begin
               state_next = HELD;
            end else begin
               state_next = ERROR;
               cnt_next   = '0;
            end
         end

         ERROR: begin
            if (is_zero) begin
               cnt_next = cnt_inc;
               if (cnt_inc == CNT_DONE) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            end else begin
               cnt_next = '0;
            end
         end

         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase

      if (accept) begin
         state_next      = HELD;
         key_valid_next  = 1'b1;
         key_code_next   = CODE_W'(onehot_to_idx(MAX_KEYS'(cand_next)));
         key_onehot_next = cand_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         cand_reg       <= '0;
         key_valid_reg  <= 1'b0;
         key_code_reg   <= '0;
         key_onehot_reg <= '0;
         err_reg        <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         cand_reg       <= cand_next;
         key_valid_reg  <= key_valid_next;
         key_code_reg   <= key_code_next;
         key_onehot_reg <= key_onehot_next;
         err_reg        <= (state_next == ERROR);
         busy_reg       <= (state_next != IDLE);
      end
   end

   assign key_valid  = key_valid_reg;
   assign key_code   = key_code_reg;
   assign key_onehot = key_onehot_reg;
   assign err        = err_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_key_event_controller.sv
// Directed latency scenarios plus randomized key traffic checked every cycle
// against a rule-level reference model of the key event controller.
module tb_key_event_controller;

   localparam int N  = 4;
   localparam int DC = 4;
   localparam int CW = 2;

   localparam int P_QUIET    = 0;
   localparam int P_SETTLING = 1;
   localparam int P_DOWN     = 2;
   localparam int P_LIFTING  = 3;
   localparam int P_FAULT    = 4;

   logic          clk;
   logic          rst;
   logic [N-1:0]  key_in;
   logic          key_valid;
   logic [CW-1:0] key_code;
   logic [N-1:0]  key_onehot;
   logic          err;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int           m_phase;
   int           m_cnt;
   logic [N-1:0] m_cand, m_s1, m_s2;
   logic         e_kv;
   logic [CW-1:0] e_code;
   logic [N-1:0] e_oh;

   // per-run observations (tick index within the run, -1 = never)
   int first_kv, kv_count, first_err, first_noerr, first_idle, busy_hi;

   key_event_controller #(
      .N_KEYS         (N),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_onehot(key_onehot),
      .err       (err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      int           n;
      logic [N-1:0] s;
      e_kv = 1'b0;
      if (rst) begin
         m_phase = P_QUIET; m_cnt = 0; m_cand = '0; m_s1 = '0; m_s2 = '0;
         e_code = '0; e_oh = '0;
         return;
      end
      s = m_s2;
      n = $countones(s);
      case (m_phase)
         P_QUIET:
            if (n >= 2) begin m_phase = P_FAULT; m_cnt = 0; end
            else if (n == 1) begin m_cand = s; m_cnt = 1; m_phase = P_SETTLING; end
         P_SETTLING:
            if (n >= 2) begin m_phase = P_FAULT; m_cnt = 0; end
            else if (n == 0) m_phase = P_QUIET;
            else if (s == m_cand) m_cnt++;
            else begin m_cand = s; m_cnt = 1; end
         P_DOWN:
            if (n == 0) begin m_phase = P_LIFTING; m_cnt = 1; end
            else if (s != m_cand) begin m_phase = P_FAULT; m_cnt = 0; end
         P_LIFTING:
            if (n == 0) m_cnt++;
            else if (s == m_cand) m_phase = P_DOWN;
            else begin m_phase = P_FAULT; m_cnt = 0; end
         default:
            if (n == 0) m_cnt++; else m_cnt = 0;
      endcase
      if (m_phase == P_SETTLING && m_cnt == DC) begin
         m_phase = P_DOWN;
         e_kv    = 1'b1;
         e_oh    = m_cand;
         for (int i = 0; i < N; i++) if (m_cand[i]) e_code = CW'(i);
      end
      if ((m_phase == P_LIFTING || m_phase == P_FAULT) && m_cnt == DC) m_phase = P_QUIET;
      m_s2 = m_s1;
      m_s1 = key_in;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("key_valid", 32'(key_valid), 32'(e_kv));
      check("key_code", 32'(key_code), 32'(e_code));
      check("key_onehot", 32'(key_onehot), 32'(e_oh));
      check("err", 32'(err), 32'(m_phase == P_FAULT));
      check("busy", 32'(busy), 32'(m_phase != P_QUIET));
      check("kv_err_excl", 32'(key_valid & err), 32'd0);
   endtask

   task automatic run_cycles(input int n);
      first_kv = -1; kv_count = 0; first_err = -1; first_noerr = -1;
      first_idle = -1; busy_hi = 0;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (key_valid) begin
            kv_count++;
            if (first_kv < 0) first_kv = i;
         end
         if (err && first_err < 0) first_err = i;
         if (!err && first_noerr < 0) first_noerr = i;
         if (!busy && first_idle < 0) first_idle = i;
         if (busy) busy_hi++;
      end
   endtask

   initial begin
      int           r, len, k;
      logic         bounce, rst_seg;
      logic [N-1:0] pat;

      rst = 1'b1;
      key_in = 4'b1111;
      @(negedge clk);

      // reset with every key pressed
      run_cycles(3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_code", 32'(key_code), 32'd0);
      rst = 1'b0;
      key_in = '0;
      run_cycles(10);
      check("idle_busy_hi", 32'(busy_hi), 32'd0);
      $display("reset: busy=%0d err=%0d", busy, err);

      // clean press, long hold, release
      key_in = 4'b0010;
      run_cycles(60);
      check("press_first_kv", 32'(first_kv), 32'd6);
      check("press_kv_count", 32'(kv_count), 32'd1);
      check("press_code", 32'(key_code), 32'd1);
      check("press_onehot", 32'(key_onehot), 32'b0010);
      key_in = '0;
      run_cycles(10);
      check("release_idle_at", 32'(first_idle), 32'd6);
      $display("clean press: kv@%0d code=%0d", 6, key_code);

      // bouncing press then stable
      for (int i = 0; i < 20; i++) begin
         key_in = ((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
         run_cycles(1);
         check("bounce_no_kv", 32'(kv_count), 32'd0);
      end
      key_in = 4'b0100;
      run_cycles(20);
      check("bounce_first_kv", 32'(first_kv), 32'd6);
      check("bounce_kv_count", 32'(kv_count), 32'd1);
      check("bounce_code", 32'(key_code), 32'd2);
      key_in = '0;
      run_cycles(10);
      $display("bounce: code=%0d", key_code);

      // multi-key press
      key_in = 4'b1001;
      run_cycles(10);
      check("multi_first_err", 32'(first_err), 32'd3);
      check("multi_kv_count", 32'(kv_count), 32'd0);
      key_in = '0;
      run_cycles(10);
      check("multi_err_clear", 32'(first_noerr), 32'd6);
      key_in = 4'b1000;
      run_cycles(10);
      check("after_multi_kv", 32'(first_kv), 32'd6);
      check("after_multi_code", 32'(key_code), 32'd3);
      key_in = '0;
      run_cycles(10);
      $display("multi press: recovered code=%0d", key_code);

      // extra key added while held
      key_in = 4'b0001;
      run_cycles(8);
      check("extra_first_kv", 32'(first_kv), 32'd6);
      key_in = 4'b0101;
      run_cycles(8);
      check("extra_first_err", 32'(first_err), 32'd3);
      check("extra_kv_count", 32'(kv_count), 32'd0);
      check("extra_code", 32'(key_code), 32'd0);
      key_in = '0;
      run_cycles(10);
      check("extra_err_clear", 32'(first_noerr), 32'd6);
      $display("extra key: err cleared, code=%0d", key_code);

      // reset pulsed mid-debounce
      key_in = 4'b0001;
      run_cycles(4);
      check("rstmid_kv_pre", 32'(kv_count), 32'd0);
      rst = 1'b1;
      run_cycles(1);
      rst = 1'b0;
      run_cycles(10);
      check("rstmid_first_kv", 32'(first_kv), 32'd6);
      check("rstmid_kv_count", 32'(kv_count), 32'd1);
      key_in = '0;
      run_cycles(10);
      $display("reset mid-debounce: kv at cycle 11");

      // randomized traffic against the model
      for (int seg = 0; seg < 300; seg++) begin
         r       = $urandom_range(0, 9);
         len     = $urandom_range(1, 12);
         k       = $urandom_range(0, N - 1);
         bounce  = 1'b0;
         rst_seg = ($urandom_range(0, 39) == 0);
         if (r < 3) pat = '0;
         else if (r < 7) pat = N'(1 << k);
         else if (r < 9) begin
            pat = N'($urandom_range(3, 15));
            while ($countones(pat) < 2) pat = N'($urandom_range(3, 15));
         end else begin
            pat = N'(1 << k);
            bounce = 1'b1;
         end
         for (int i = 0; i < len; i++) begin
            key_in = (bounce && (i % 2 == 1)) ? '0 : pat;
            rst = rst_seg && (i == 0);
            tick();
         end
         rst = 1'b0;
      end
      $display("random traffic: %0d segments", 300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
